// File: rtl/ram_seq_writer_pkg.sv
// Shared types and constants for the sequential RAM writer.
// Optional test-pattern source is enabled by defining RAM_SEQ_WRITER_PATTERN_EN.
package ram_seq_writer_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 4;

    // A programmed length of zero selects a burst covering the whole RAM.
    localparam int LEN_FULL_DEPTH_CODE = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } wr_state_e;

    function automatic int unsigned burst_beats(input int unsigned len, input int unsigned addr_w);
        return (len == LEN_FULL_DEPTH_CODE) ? (32'd1 << addr_w) : len;
    endfunction

endpackage

// File: rtl/ram_seq_writer_if.sv
// Control, source handshake and RAM write-port bundle for ram_seq_writer.
// pattern_mode exists only when RAM_SEQ_WRITER_PATTERN_EN is defined.
interface ram_seq_writer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int CNT_W  = ADDR_W + 1
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  length;
    logic              tick;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
`ifdef RAM_SEQ_WRITER_PATTERN_EN
    logic              pattern_mode;

    modport master (
        output start, base_addr, length, tick, din, din_valid, pattern_mode,
        input  din_ready, wr_addr, wr_data, wr_en, busy, done, count
    );
    modport slave (
        input  start, base_addr, length, tick, din, din_valid, pattern_mode,
        output din_ready, wr_addr, wr_data, wr_en, busy, done, count
    );
`else
    modport master (
        output start, base_addr, length, tick, din, din_valid,
        input  din_ready, wr_addr, wr_data, wr_en, busy, done, count
    );
    modport slave (
        input  start, base_addr, length, tick, din, din_valid,
        output din_ready, wr_addr, wr_data, wr_en, busy, done, count
    );
`endif
endinterface

// File: rtl/ram_seq_writer_tick_gen.sv
// Clock-enable divider: tick_o is high for one clk cycle out of every DIV.
// DIV=1 keeps tick_o permanently high.
module ram_seq_writer_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == '0);
        cnt_d  = tick_o ? CW'(DIV - 1) : cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ram_seq_writer.sv
// Burst writer: accepts nibbles over valid/ready and writes them to consecutive RAM
// addresses from a latched base. Optional pattern fill via RAM_SEQ_WRITER_PATTERN_EN.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; din_ready low; count holds last burst total
//   ST_ACTIVE | accepting beats whenever the pacing tick is high
//   ST_DONE   | one cycle coinciding with the final write; done high
module ram_seq_writer
    import ram_seq_writer_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = ADDR_W + 1,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    ram_seq_writer_if.slave    bus
);
    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              pat_q, pat_d;
    logic              pat_start;
    logic              gen_tick;
    logic              tick_en;
    logic              din_ready;
    logic              beat;
    logic [DATA_W-1:0] beat_data;

    ram_seq_writer_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_o (gen_tick)
    );

    // External pacing and the internal divider both gate acceptance.
    assign tick_en = bus.tick & gen_tick;

`ifdef RAM_SEQ_WRITER_PATTERN_EN
    assign pat_start = bus.pattern_mode;
`else
    assign pat_start = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        pat_d       = pat_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        din_ready   = 1'b0;
        beat        = 1'b0;
        beat_data   = bus.din;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cur_addr_d  = bus.base_addr;
                    remaining_d = CNT_W'(burst_beats(32'(bus.length), ADDR_W));
                    count_d     = '0;
                    pat_d       = pat_start;
                    state_d     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (pat_q) begin
                    beat      = tick_en;
                    beat_data = count_q[DATA_W-1:0];
                end else begin
                    din_ready = tick_en;
                    beat      = bus.din_valid & tick_en;
                end
                if (beat) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = cur_addr_q;
                    wr_data_d   = beat_data;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    count_d     = count_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            pat_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            pat_q       <= pat_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_ram_seq_writer.sv
// Scoreboard bench for ram_seq_writer: a burst-level model queues expected writes,
// an independent monitor checks every RAM write cycle against the queue.
module tb_ram_seq_writer;
    logic clk = 1'b0;
    logic rst_b;
    bit   mon_en = 1'b0;
    bit   pat_drive = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int a;
        int d;
        int c;
        bit dn;
    } exp_t;
    exp_t q[$];

    // Burst-level reference state.
    int   m_rem = 0;
    int   m_cnt = 0;
    logic [4:0] m_addr = '0;
    bit   m_done = 1'b0;
    bit   m_pat = 1'b0;
    bit   beat_taken;

    ram_seq_writer_if #(.ADDR_W(5), .DATA_W(4), .CNT_W(6)) bus ();

    ram_seq_writer #(.ADDR_W(5), .DATA_W(4), .CNT_W(6), .TICK_DIV(1)) dut (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t me;
        if (mon_en) begin
            if (bus.wr_en === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got write to %0h, expected none", bus.wr_addr);
                end else begin
                    me = q.pop_front();
                    chk("wr_addr", 32'(bus.wr_addr), me.a);
                    chk("wr_data", 32'(bus.wr_data), me.d);
                    chk("done_at_write", 32'(bus.done), 32'(me.dn));
                    chk("count_at_write", 32'(bus.count), me.c);
                end
            end else begin
                chk("wr_en", 32'(bus.wr_en), 32'(q.size() != 0));
                chk("done_no_write", 32'(bus.done), 32'd0);
                q.delete();
            end
        end
    end

    task automatic cycle(input logic st, input logic [4:0] ba, input logic [5:0] ln,
                         input logic tk, input logic dv, input logic [3:0] d, input logic rb);
        exp_t e;
        @(negedge clk);
        #1;
        bus.start     = st;
        bus.base_addr = ba;
        bus.length    = ln;
        bus.tick      = tk;
        bus.din_valid = dv;
        bus.din       = d;
        rst_b         = rb;
`ifdef RAM_SEQ_WRITER_PATTERN_EN
        bus.pattern_mode = pat_drive;
`endif
        #1;
        beat_taken = 1'b0;
        if (!rb) begin
            m_rem = 0; m_done = 1'b0; m_cnt = 0; m_pat = 1'b0;
        end else begin
            chk("busy", 32'(bus.busy), 32'((m_rem != 0) || m_done));
            chk("din_ready", 32'(bus.din_ready), 32'((m_rem != 0) && !m_pat && tk));
            chk("count", 32'(bus.count), m_cnt);
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_rem != 0) begin
                if (tk && (m_pat || dv)) begin
                    e.a = int'(m_addr);
                    e.d = m_pat ? (m_cnt % 16) : int'(d);
                    m_cnt++;
                    m_rem--;
                    e.c  = m_cnt;
                    e.dn = (m_rem == 0);
                    q.push_back(e);
                    m_addr = m_addr + 5'd1;
                    if (m_rem == 0) m_done = 1'b1;
                    beat_taken = 1'b1;
                end
            end else if (st) begin
                m_addr = ba;
                m_rem  = (ln == 6'd0) ? 32 : int'(ln);
                m_cnt  = 0;
                m_pat  = pat_drive;
            end
        end
    endtask

    task automatic burst(input logic [4:0] ba, input logic [5:0] ln, input int div,
                         input bit rnd_valid, input bit spurious);
        logic [3:0] d;
        logic tk, dv, st;
        int k;
        d = 4'($urandom);
        cycle(1'b1, ba, ln, 1'b1, 1'b0, d, 1'b1);
        k = 0;
        while ((m_rem != 0 || m_done) && k < 400) begin
            tk = ((k % div) == (div - 1));
            dv = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            st = spurious && ($urandom_range(0, 2) == 0);
            cycle(st, 5'($urandom), 6'($urandom), tk, dv, d, 1'b1);
            if (beat_taken) d = 4'($urandom);
            k++;
        end
        if (k >= 400) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got still busy after %0d cycles, expected completion", k);
        end
        cycle(1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 4'd0, 1'b1);
    endtask

    initial begin
        logic [5:0] ln;
        rst_b = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.tick = 1'b0; bus.din = '0; bus.din_valid = 1'b0;
`ifdef RAM_SEQ_WRITER_PATTERN_EN
        bus.pattern_mode = 1'b0;
`endif
        repeat (3) cycle(1'b0, 5'd0, 6'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        mon_en = 1'b1;
        cycle(1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 4'd0, 1'b1);
        chk("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("reset_wr_data", 32'(bus.wr_data), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);

        // Directed three-beat burst.
        cycle(1'b1, 5'h04, 6'd3, 1'b1, 1'b0, 4'h0, 1'b1);
        cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b1, 4'hA, 1'b1);
        cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b1, 4'hB, 1'b1);
        cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b1, 4'hC, 1'b1);
        repeat (3) cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b1, 4'h0, 1'b1);
        chk("count_hold", 32'(bus.count), 32'd3);

        burst(5'h1E, 6'd4, 1, 1'b0, 1'b0);
        burst(5'h00, 6'd0, 1, 1'b0, 1'b0);
        chk("full_depth_count", 32'(bus.count), 32'd32);
        burst(5'($urandom), 6'd2, 4, 1'b0, 1'b1);

        // Reset two beats into a five-beat burst.
        cycle(1'b1, 5'h08, 6'd5, 1'b1, 1'b0, 4'h0, 1'b1);
        cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b1, 4'h3, 1'b1);
        cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b1, 4'h5, 1'b1);
        cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b1, 4'h6, 1'b0);
        repeat (2) cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b1, 4'h6, 1'b1);
        chk("post_reset_count", 32'(bus.count), 32'd0);
        burst(5'h08, 6'd5, 1, 1'b0, 1'b0);

        repeat (20) begin
            ln = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 10));
            burst(5'($urandom), ln, $urandom_range(1, 4), 1'b1, 1'b1);
        end

`ifdef RAM_SEQ_WRITER_PATTERN_EN
        pat_drive = 1'b1;
        burst(5'h10, 6'd18, 1, 1'b1, 1'b0);
        burst(5'($urandom), 6'd7, 2, 1'b1, 1'b1);
        pat_drive = 1'b0;
        burst(5'h03, 6'd3, 1, 1'b0, 1'b0);
`endif

        repeat (3) cycle(1'b0, 5'h00, 6'd0, 1'b1, 1'b0, 4'h0, 1'b1);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
